nb_seq_checker: RTL and testbench

//  Receiving end of the 4-register update sequence (a<=b+c; d<=a-3; b<=d+10; c<=c+1).

---
 rtl/nb_seq_checker_if.sv | 15 +
 rtl/nb_seq_checker.sv | 218 +++++++++++++++++++++
 tb/tb_nb_seq_checker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nb_seq_checker_if.sv
// Sample stream into nb_seq_checker: one {a,b,c,d} sample per valid/ready transfer.
// The generator drives the master side; the checker is the slave.
interface nb_seq_checker_if #(
  parameter int WIDTH = 32
) ();
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic [WIDTH-1:0] s_c;
  logic [WIDTH-1:0] s_d;

  modport master (output s_valid, s_a, s_b, s_c, s_d, input s_ready);
  modport slave  (input s_valid, s_a, s_b, s_c, s_d, output s_ready);
endinterface

// File: rtl/nb_seq_checker.sv
// Self-checking sink for the sequence a<=b+c; d<=a-D; b<=d+B; c<=c+C.
// Predicts each sample from the previous one. Defining NB_SEQ_CHK_CAPTURE_EN adds first-error capture ports.
module nb_seq_checker #(
  parameter int WIDTH       = 32,
  parameter int D_OFFSET    = 3,
  parameter int B_OFFSET    = 10,
  parameter int C_STEP      = 1,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  nb_seq_checker_if.slave  s,
  output logic             chk_valid,
  output logic [3:0]       err_mask,
  output logic             err_flag,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef NB_SEQ_CHK_CAPTURE_EN
  ,
  output logic               cap_valid,
  output logic [CNT_W-1:0]   cap_idx,
  output logic [4*WIDTH-1:0] cap_exp,
  output logic [4*WIDTH-1:0] cap_act
`endif
);

  localparam logic [1:0] ST_SEED  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [WIDTH-1:0] D_OFF  = WIDTH'(D_OFFSET);
  localparam logic [WIDTH-1:0] B_OFF  = WIDTH'(B_OFFSET);
  localparam logic [WIDTH-1:0] C_INC  = WIDTH'(C_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]       state_q,      state_d;
  logic             ready_q,      ready_d;
  logic             chk_valid_q,  chk_valid_d;
  logic [3:0]       err_mask_q,   err_mask_d;
  logic             err_flag_q,   err_flag_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] match_cnt_q,  match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
  logic [WIDTH-1:0] prev_a_q,     prev_a_d;
  logic [WIDTH-1:0] prev_b_q,     prev_b_d;
  logic [WIDTH-1:0] prev_c_q,     prev_c_d;
  logic [WIDTH-1:0] prev_d_q,     prev_d_d;
`ifdef NB_SEQ_CHK_CAPTURE_EN
  logic               cap_valid_q, cap_valid_d;
  logic [CNT_W-1:0]   cap_idx_q,   cap_idx_d;
  logic [4*WIDTH-1:0] cap_exp_q,   cap_exp_d;
  logic [4*WIDTH-1:0] cap_act_q,   cap_act_d;
`endif

  logic             xfer;
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;
  logic [WIDTH-1:0] exp_c;
  logic [WIDTH-1:0] exp_d;
  logic [3:0]       mism;

  assign xfer  = s.s_valid & ready_q;
  assign exp_a = prev_b_q + prev_c_q;
  assign exp_b = prev_d_q + B_OFF;
  assign exp_c = prev_c_q + C_INC;
  assign exp_d = prev_a_q - D_OFF;
  assign mism  = {(s.s_a != exp_a), (s.s_b != exp_b), (s.s_c != exp_c), (s.s_d != exp_d)};

  // Next-state: clr beats a same-cycle transfer; prev always tracks the received sample.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    chk_valid_d  = 1'b0;
    err_mask_d   = err_mask_q;
    err_flag_d   = err_flag_q;
    sample_cnt_d = sample_cnt_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    prev_a_d     = prev_a_q;
    prev_b_d     = prev_b_q;
    prev_c_d     = prev_c_q;
    prev_d_d     = prev_d_q;
`ifdef NB_SEQ_CHK_CAPTURE_EN
    cap_valid_d  = cap_valid_q;
    cap_idx_d    = cap_idx_q;
    cap_exp_d    = cap_exp_q;
    cap_act_d    = cap_act_q;
`endif
    if (clr) begin
      state_d      = ST_SEED;
      ready_d      = 1'b1;
      err_mask_d   = 4'b0000;
      err_flag_d   = 1'b0;
      sample_cnt_d = '0;
      match_cnt_d  = '0;
      err_cnt_d    = '0;
      prev_a_d     = '0;
      prev_b_d     = '0;
      prev_c_d     = '0;
      prev_d_d     = '0;
`ifdef NB_SEQ_CHK_CAPTURE_EN
      cap_valid_d  = 1'b0;
      cap_idx_d    = '0;
      cap_exp_d    = '0;
      cap_act_d    = '0;
`endif
    end else if (xfer) begin
      sample_cnt_d = sat_inc(sample_cnt_q);
      prev_a_d     = s.s_a;
      prev_b_d     = s.s_b;
      prev_c_d     = s.s_c;
      prev_d_d     = s.s_d;
      case (state_q)
        ST_SEED: begin
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          chk_valid_d = 1'b1;
          err_mask_d  = mism;
          if (|mism) begin
            err_flag_d = 1'b1;
            err_cnt_d  = sat_inc(err_cnt_q);
`ifdef NB_SEQ_CHK_CAPTURE_EN
            if (!cap_valid_q) begin
              cap_valid_d = 1'b1;
              cap_idx_d   = sample_cnt_q;
              cap_exp_d   = {exp_a, exp_b, exp_c, exp_d};
              cap_act_d   = {s.s_a, s.s_b, s.s_c, s.s_d};
            end else begin
              cap_valid_d = cap_valid_q;
            end
`endif
            if (STOP_ON_ERR != 0) begin
              state_d = ST_HALT;
              ready_d = 1'b0;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            match_cnt_d = sat_inc(match_cnt_q);
          end
        end
        default: begin
          // Unreachable with ready low in HALT; re-seed from any illegal encoding.
          state_d = ST_SEED;
          ready_d = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= ST_SEED;
      ready_q      <= 1'b1;
      chk_valid_q  <= 1'b0;
      err_mask_q   <= 4'b0000;
      err_flag_q   <= 1'b0;
      sample_cnt_q <= '0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      prev_a_q     <= '0;
      prev_b_q     <= '0;
      prev_c_q     <= '0;
      prev_d_q     <= '0;
`ifdef NB_SEQ_CHK_CAPTURE_EN
      cap_valid_q  <= 1'b0;
      cap_idx_q    <= '0;
      cap_exp_q    <= '0;
      cap_act_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      chk_valid_q  <= chk_valid_d;
      err_mask_q   <= err_mask_d;
      err_flag_q   <= err_flag_d;
      sample_cnt_q <= sample_cnt_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      prev_a_q     <= prev_a_d;
      prev_b_q     <= prev_b_d;
      prev_c_q     <= prev_c_d;
      prev_d_q     <= prev_d_d;
`ifdef NB_SEQ_CHK_CAPTURE_EN
      cap_valid_q  <= cap_valid_d;
      cap_idx_q    <= cap_idx_d;
      cap_exp_q    <= cap_exp_d;
      cap_act_q    <= cap_act_d;
`endif
    end
  end

  assign s.s_ready  = ready_q;
  assign chk_valid  = chk_valid_q;
  assign err_mask   = err_mask_q;
  assign err_flag   = err_flag_q;
  assign sample_cnt = sample_cnt_q;
  assign match_cnt  = match_cnt_q;
  assign err_cnt    = err_cnt_q;
`ifdef NB_SEQ_CHK_CAPTURE_EN
  assign cap_valid  = cap_valid_q;
  assign cap_idx    = cap_idx_q;
  assign cap_exp    = cap_exp_q;
  assign cap_act    = cap_act_q;
`endif

endmodule

// File: tb/tb_nb_seq_checker.sv
// Scoreboard bench for nb_seq_checker: dut0 is 32-bit free-running, dut1 is 8-bit with stop-on-error.
// Capture checks compile in when NB_SEQ_CHK_CAPTURE_EN is defined.
module tb_nb_seq_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n0, clr0, rst_n1, clr1;
  nb_seq_checker_if #(.WIDTH(32)) s0 ();
  nb_seq_checker_if #(.WIDTH(8))  s1 ();

  logic        chk_valid0, chk_valid1;
  logic [3:0]  err_mask0, err_mask1;
  logic        err_flag0, err_flag1;
  logic [15:0] sample_cnt0, match_cnt0, err_cnt0;
  logic [15:0] sample_cnt1, match_cnt1, err_cnt1;
`ifdef NB_SEQ_CHK_CAPTURE_EN
  logic         cap_valid0, cap_valid1;
  logic [15:0]  cap_idx0, cap_idx1;
  logic [127:0] cap_exp0, cap_act0;
  logic [31:0]  cap_exp1, cap_act1;
`endif

  nb_seq_checker #(.WIDTH(32), .STOP_ON_ERR(0)) dut0 (
    .clock(clock), .rst_n(rst_n0), .clr(clr0), .s(s0),
    .chk_valid(chk_valid0), .err_mask(err_mask0), .err_flag(err_flag0),
    .sample_cnt(sample_cnt0), .match_cnt(match_cnt0), .err_cnt(err_cnt0)
`ifdef NB_SEQ_CHK_CAPTURE_EN
    , .cap_valid(cap_valid0), .cap_idx(cap_idx0), .cap_exp(cap_exp0), .cap_act(cap_act0)
`endif
  );

  nb_seq_checker #(.WIDTH(8), .STOP_ON_ERR(1)) dut1 (
    .clock(clock), .rst_n(rst_n1), .clr(clr1), .s(s1),
    .chk_valid(chk_valid1), .err_mask(err_mask1), .err_flag(err_flag1),
    .sample_cnt(sample_cnt1), .match_cnt(match_cnt1), .err_cnt(err_cnt1)
`ifdef NB_SEQ_CHK_CAPTURE_EN
    , .cap_valid(cap_valid1), .cap_idx(cap_idx1), .cap_exp(cap_exp1), .cap_act(cap_act1)
`endif
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic        flag;
    logic [15:0] smp;
    logic [15:0] mat;
    logic [15:0] err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t t0, t1;

  // Reference model state, one slot per DUT.
  logic [31:0] m_prev [2][4];
  bit          m_seeded [2];
  bit          m_halt [2];
  bit          m_flag [2];
  logic [3:0]  m_last_mask [2];
  logic [15:0] m_smp [2];
  logic [15:0] m_mat [2];
  logic [15:0] m_err [2];
  int          m_width [2] = '{32, 8};
  bit          m_stop [2]  = '{1'b0, 1'b1};
  bit          m_cap_v;
  logic [15:0] m_cap_idx;
  logic [127:0] m_cap_exp, m_cap_act;

  function automatic logic [31:0] trunc(input int id, input logic [31:0] v);
    if (m_width[id] >= 32) return v;
    return v & ((32'h1 << m_width[id]) - 32'h1);
  endfunction

  task automatic model_clear(input int id);
    for (int k = 0; k < 4; k++) m_prev[id][k] = 32'h0;
    m_seeded[id] = 1'b0;
    m_halt[id] = 1'b0;
    m_flag[id] = 1'b0;
    m_last_mask[id] = 4'b0000;
    m_smp[id] = 16'd0;
    m_mat[id] = 16'd0;
    m_err[id] = 16'd0;
    if (id == 0) begin
      m_cap_v = 1'b0;
      m_cap_idx = 16'd0;
      m_cap_exp = 128'h0;
      m_cap_act = 128'h0;
    end
  endtask

  task automatic model_xfer(input int id, input logic [31:0] a, b, c, d);
    logic [31:0] e [4];
    logic [3:0] mask;
    exp_t t;
    if (!m_seeded[id]) begin
      m_seeded[id] = 1'b1;
      m_smp[id]++;
    end else begin
      e[0] = trunc(id, m_prev[id][1] + m_prev[id][2]);
      e[1] = trunc(id, m_prev[id][3] + 32'd10);
      e[2] = trunc(id, m_prev[id][2] + 32'd1);
      e[3] = trunc(id, m_prev[id][0] - 32'd3);
      mask = {a != e[0], b != e[1], c != e[2], d != e[3]};
      if (id == 0 && mask != 4'b0000 && !m_cap_v) begin
        m_cap_v = 1'b1;
        m_cap_idx = m_smp[id];
        m_cap_exp = {e[0], e[1], e[2], e[3]};
        m_cap_act = {a, b, c, d};
      end
      m_smp[id]++;
      if (mask != 4'b0000) begin
        m_flag[id] = 1'b1;
        m_err[id]++;
        if (m_stop[id]) m_halt[id] = 1'b1;
      end else begin
        m_mat[id]++;
      end
      m_last_mask[id] = mask;
      t = '{mask: mask, flag: m_flag[id], smp: m_smp[id], mat: m_mat[id], err: m_err[id]};
      if (id == 0) q0.push_back(t);
      else q1.push_back(t);
    end
    m_prev[id][0] = a;
    m_prev[id][1] = b;
    m_prev[id][2] = c;
    m_prev[id][3] = d;
  endtask

  task automatic send(input int id, input logic [31:0] a, b, c, d);
    logic [31:0] ta, tb, tc, td;
    ta = trunc(id, a); tb = trunc(id, b); tc = trunc(id, c); td = trunc(id, d);
    if (id == 0) begin
      s0.s_valid = 1'b1; s0.s_a = ta; s0.s_b = tb; s0.s_c = tc; s0.s_d = td;
      chk_eq("ready0", s0.s_ready, !m_halt[0]);
    end else begin
      s1.s_valid = 1'b1; s1.s_a = ta[7:0]; s1.s_b = tb[7:0]; s1.s_c = tc[7:0]; s1.s_d = td[7:0];
      chk_eq("ready1", s1.s_ready, !m_halt[1]);
    end
    if (!m_halt[id]) model_xfer(id, ta, tb, tc, td);
    @(posedge clock); #1;
    s0.s_valid = 1'b0;
    s1.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_clr(input int id);
    if (id == 0) clr0 = 1'b1; else clr1 = 1'b1;
    @(posedge clock); #1;
    clr0 = 1'b0; clr1 = 1'b0;
    model_clear(id);
  endtask

  task automatic snap(input int id);
    if (id == 0) begin
      chk_eq("ready0_s", s0.s_ready, !m_halt[0]);
      chk_eq("smp0", sample_cnt0, m_smp[0]);
      chk_eq("mat0", match_cnt0, m_mat[0]);
      chk_eq("err0", err_cnt0, m_err[0]);
      chk_eq("flag0", err_flag0, m_flag[0]);
      chk_eq("mask0_hold", err_mask0, m_last_mask[0]);
    end else begin
      chk_eq("ready1_s", s1.s_ready, !m_halt[1]);
      chk_eq("smp1", sample_cnt1, m_smp[1]);
      chk_eq("mat1", match_cnt1, m_mat[1]);
      chk_eq("err1", err_cnt1, m_err[1]);
      chk_eq("flag1", err_flag1, m_flag[1]);
      chk_eq("mask1_hold", err_mask1, m_last_mask[1]);
    end
  endtask

  // Pop the oldest prediction whenever a DUT reports a comparison.
  always @(negedge clock) begin
    if (chk_valid0) begin
      if (q0.size() == 0) chk_eq("chk0_unexpected", chk_valid0, 1'b0);
      else begin
        t0 = q0.pop_front();
        chk_eq("mask0", err_mask0, t0.mask);
        chk_eq("flag0_c", err_flag0, t0.flag);
        chk_eq("smp0_c", sample_cnt0, t0.smp);
        chk_eq("mat0_c", match_cnt0, t0.mat);
        chk_eq("err0_c", err_cnt0, t0.err);
      end
    end
    if (chk_valid1) begin
      if (q1.size() == 0) chk_eq("chk1_unexpected", chk_valid1, 1'b0);
      else begin
        t1 = q1.pop_front();
        chk_eq("mask1", err_mask1, t1.mask);
        chk_eq("flag1_c", err_flag1, t1.flag);
        chk_eq("smp1_c", sample_cnt1, t1.smp);
        chk_eq("mat1_c", match_cnt1, t1.mat);
        chk_eq("err1_c", err_cnt1, t1.err);
      end
    end
  end

  initial begin
    s0.s_valid = 1'b0; s0.s_a = '0; s0.s_b = '0; s0.s_c = '0; s0.s_d = '0;
    s1.s_valid = 1'b0; s1.s_a = '0; s1.s_b = '0; s1.s_c = '0; s1.s_d = '0;
    rst_n0 = 1'b0; rst_n1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clock);
    #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    snap(0);
    snap(1);
    chk_eq("chk_valid0_rst", chk_valid0, 1'b0);

    // Clean sequence: two matching comparisons.
    send(0, 32'd30, 32'd20, 32'd15, 32'd5);
    send(0, 32'd35, 32'd15, 32'd16, 32'd27);
    send(0, 32'd31, 32'd37, 32'd17, 32'd32);
    idle(2);
    snap(0);

    // Single bad field, then a sample consistent with the bad one.
    pulse_clr(0);
    snap(0);
    send(0, 32'd30, 32'd20, 32'd15, 32'd5);
    send(0, 32'd36, 32'd15, 32'd16, 32'd27);
    send(0, 32'd31, 32'd37, 32'd17, 32'd33);
    idle(2);
    snap(0);

    // Reset mid-stream re-seeds; valid gaps change nothing.
    send(0, 32'd40, 32'd1, 32'd2, 32'd3);
    rst_n0 = 1'b0;
    @(posedge clock); #1;
    rst_n0 = 1'b1;
    model_clear(0);
    snap(0);
    send(0, 32'd100, 32'd200, 32'd300, 32'd400);
    idle(3);
    snap(0);
    send(0, 32'd500, 32'd410, 32'd301, 32'd97);
    idle(3);
    send(0, 32'd711, 32'd107, 32'd302, 32'd497);
    idle(2);
    snap(0);

    // clr wins over a same-cycle transfer.
    clr0 = 1'b1;
    s0.s_valid = 1'b1; s0.s_a = 32'd9; s0.s_b = 32'd9; s0.s_c = 32'd9; s0.s_d = 32'd9;
    @(posedge clock); #1;
    clr0 = 1'b0; s0.s_valid = 1'b0;
    model_clear(0);
    idle(1);
    snap(0);

    // Errors at samples 2 and 4; only the first is captured.
    send(0, 32'd1, 32'd2, 32'd3, 32'd4);
    send(0, 32'd5, 32'd14, 32'd4, 32'hFFFF_FFFE);
    send(0, 32'd18, 32'd8, 32'd5, 32'd99);
    send(0, 32'd13, 32'd109, 32'd6, 32'd15);
    send(0, 32'd115, 32'd25, 32'd8, 32'd10);
    idle(2);
    snap(0);
`ifdef NB_SEQ_CHK_CAPTURE_EN
    chk_eq("cap_valid0", cap_valid0, m_cap_v);
    chk_eq("cap_idx0", cap_idx0, m_cap_idx);
    chk_eq("cap_exp0", cap_exp0, m_cap_exp);
    chk_eq("cap_act0", cap_act0, m_cap_act);
`endif

    // 8-bit wrap-around match, then a d mismatch halts dut1.
    send(1, 32'd0, 32'd127, 32'd127, 32'd250);
    send(1, 32'd254, 32'd4, 32'd128, 32'd253);
    send(1, 32'd132, 32'd7, 32'd129, 32'd0);
    idle(1);
    snap(1);
    send(1, 32'd1, 32'd2, 32'd3, 32'd4);
    send(1, 32'd5, 32'd6, 32'd7, 32'd8);
    idle(2);
    snap(1);
    pulse_clr(1);
    snap(1);
    send(1, 32'd1, 32'd1, 32'd1, 32'd1);
    send(1, 32'd2, 32'd11, 32'd2, 32'hFE);
    idle(2);
    snap(1);

    idle(3);
    chk_eq("q0_drained", q0.size(), 0);
    chk_eq("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
